// File: rtl/core_pkg.sv
// Shared types and encodings for the core sequencer.
package core_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    DRAIN = 3'd2,
    WB    = 3'd3,
    FIN   = 3'd4
  } state_e;

  localparam int unsigned INST_W = 2;

  localparam logic [INST_W-1:0] INST_NONE  = 2'b00;
  localparam logic [INST_W-1:0] INST_KLOAD = 2'b01;
  localparam logic [INST_W-1:0] INST_EXEC  = 2'b10;

  localparam logic MODE_KLOAD = 1'b0;
  localparam logic MODE_EXEC  = 1'b1;

  // Array instruction that accompanies every L0 write for a given command mode.
  function automatic logic [INST_W-1:0] inst_for(input logic mode);
    return (mode == MODE_EXEC) ? INST_EXEC : INST_KLOAD;
  endfunction

endpackage

// File: rtl/core_rd_stream.sv
// Input-SRAM read streamer: issues reads, tracks the 1-cycle return and
// forwards words into L0, parking one word in a hold register under back-pressure.
module core_rd_stream
  import core_pkg::*;
#(
  parameter int unsigned bw     = 4,
  parameter int unsigned row    = 8,
  parameter int unsigned addr_w = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  en,
  input  logic                  mode,
  input  logic [addr_w-1:0]     rd_base,
  input  logic [addr_w:0]       len,
  input  logic                  l0_full,
  input  logic [row*bw-1:0]     sram_q,
  output logic                  sram_cen,
  output logic [addr_w-1:0]     sram_a,
  output logic                  l0_wr,
  output logic [row*bw-1:0]     l0_din,
  output logic [INST_W-1:0]     inst,
  output logic                  last_c
);

  localparam int unsigned DW = row * bw;
  localparam int unsigned CW = addr_w + 1;

  logic [CW-1:0] issued;
  logic [CW-1:0] written;
  logic          pend;
  logic          hold_v;
  logic [DW-1:0] hold_q;
  logic          issue_c;

  // A new read is only launched when the previous return has a guaranteed slot.
  always_comb begin
    issue_c  = en && (issued < len) && !l0_full && !hold_v;
    sram_cen = !issue_c;
    sram_a   = '0;
    if (issue_c) sram_a = rd_base + issued[addr_w-1:0];
    l0_wr    = en && (hold_v || pend) && !l0_full;
    l0_din   = '0;
    if (l0_wr) l0_din = hold_v ? hold_q : sram_q;
    inst     = l0_wr ? inst_for(mode) : INST_NONE;
    last_c   = l0_wr && ((written + CW'(1)) == len);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issued  <= '0;
      written <= '0;
      pend    <= 1'b0;
      hold_v  <= 1'b0;
      hold_q  <= '0;
    end else if (clr) begin
      issued  <= '0;
      written <= '0;
      pend    <= 1'b0;
      hold_v  <= 1'b0;
    end else begin
      pend <= issue_c;
      if (issue_c) issued <= issued + CW'(1);
      if (l0_wr) written <= written + CW'(1);
      // Returning word that L0 refuses is parked until the first free cycle.
      if (en && pend && l0_full) begin
        hold_v <= 1'b1;
        hold_q <= sram_q;
      end else if (hold_v && !l0_full) begin
        hold_v <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/core_ctrl.sv
// Core sequencer: start/done command FSM, L0 streaming via core_rd_stream
// and output-FIFO drain into the psum SRAM.
module core_ctrl
  import core_pkg::*;
#(
  parameter int unsigned bw      = 4,
  parameter int unsigned psum_bw = 16,
  parameter int unsigned row     = 8,
  parameter int unsigned col     = 8,
  parameter int unsigned addr_w  = 11
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     mode,
  input  logic [addr_w-1:0]        rd_base,
  input  logic [addr_w-1:0]        wb_base,
  input  logic [addr_w:0]          len,
  output logic                     busy,
  output logic                     done,
  output logic                     sram_cen,
  output logic                     sram_wen,
  output logic [addr_w-1:0]        sram_a,
  input  logic [row*bw-1:0]        sram_q,
  output logic                     l0_wr,
  output logic [row*bw-1:0]        l0_din,
  input  logic                     l0_full,
  output logic [1:0]               inst,
  input  logic                     ofifo_valid,
  input  logic [col*psum_bw-1:0]   ofifo_dout,
  output logic                     ofifo_rd,
  output logic                     psum_cen,
  output logic                     psum_wen,
  output logic [addr_w-1:0]        psum_a,
  output logic [col*psum_bw-1:0]   psum_d
);

  localparam int unsigned CW = addr_w + 1;

  state_e            state;
  state_e            state_nx;
  logic              mode_q;
  logic [addr_w-1:0] rd_base_q;
  logic [addr_w-1:0] wb_base_q;
  logic [CW-1:0]     len_q;
  logic [CW-1:0]     popped;
  logic              load_c;
  logic              drain_c;
  logic              pop_c;
  logic              last_wr_c;

  assign sram_wen = 1'b1;

  core_rd_stream #(
    .bw     (bw),
    .row    (row),
    .addr_w (addr_w)
  ) u_rd_stream (
    .clk      (clk),
    .reset    (reset),
    .clr      (state == IDLE),
    .en       (load_c),
    .mode     (mode_q),
    .rd_base  (rd_base_q),
    .len      (len_q),
    .l0_full  (l0_full),
    .sram_q   (sram_q),
    .sram_cen (sram_cen),
    .sram_a   (sram_a),
    .l0_wr    (l0_wr),
    .l0_din   (l0_din),
    .inst     (inst),
    .last_c   (last_wr_c)
  );

  // Next state and same-cycle FIFO-to-psum writeback.
  always_comb begin
    state_nx = state;
    load_c   = (state == LOAD);
    drain_c  = (state == DRAIN) || (state == WB);
    pop_c    = drain_c && ofifo_valid;
    ofifo_rd = pop_c;
    psum_cen = !pop_c;
    psum_wen = !pop_c;
    psum_a   = '0;
    psum_d   = '0;
    if (pop_c) begin
      psum_a = wb_base_q + popped[addr_w-1:0];
      psum_d = ofifo_dout;
    end
    case (state)
      IDLE:  if (start) state_nx = (len == '0) ? FIN : LOAD;
      LOAD:  if (last_wr_c) state_nx = (mode_q == MODE_EXEC) ? DRAIN : FIN;
      DRAIN,
      WB: begin
        if (pop_c) state_nx = ((popped + CW'(1)) == len_q) ? FIN : WB;
        else       state_nx = DRAIN;
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx == LOAD) || (state_nx == DRAIN) || (state_nx == WB);
      done  <= (state_nx == FIN);
    end
  end

  // Command latch and writeback counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q    <= MODE_KLOAD;
      rd_base_q <= '0;
      wb_base_q <= '0;
      len_q     <= '0;
      popped    <= '0;
    end else if (state == IDLE) begin
      popped <= '0;
      if (start) begin
        mode_q    <= mode;
        rd_base_q <= rd_base;
        wb_base_q <= wb_base;
        len_q     <= len;
      end
    end else if (pop_c) begin
      popped <= popped + CW'(1);
    end
  end

endmodule

// File: tb/tb_core_ctrl.sv
// Randomised self-checking bench for core_ctrl with a count-based behavioural model.
module tb_core_ctrl;

  localparam int unsigned BW      = 4;
  localparam int unsigned PSUM_BW = 16;
  localparam int unsigned ROW     = 8;
  localparam int unsigned COL     = 8;
  localparam int unsigned AW      = 11;
  localparam int unsigned DW      = ROW * BW;
  localparam int unsigned PW      = COL * PSUM_BW;
  localparam int          DEPTH   = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [AW-1:0] rd_base = '0;
  logic [AW-1:0] wb_base = '0;
  logic [AW:0]   len = '0;
  logic          busy, done, sram_cen, sram_wen, l0_wr, ofifo_rd, psum_cen, psum_wen;
  logic [AW-1:0] sram_a, psum_a;
  logic [DW-1:0] sram_q = '0;
  logic [DW-1:0] l0_din;
  logic          l0_full = 1'b0;
  logic [1:0]    inst;
  logic          ofifo_valid = 1'b0;
  logic [PW-1:0] ofifo_dout = '0;
  logic [PW-1:0] psum_d;

  always #5 clk = ~clk;

  core_ctrl #(.bw(BW), .psum_bw(PSUM_BW), .row(ROW), .col(COL), .addr_w(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .rd_base(rd_base),
    .wb_base(wb_base), .len(len), .busy(busy), .done(done), .sram_cen(sram_cen),
    .sram_wen(sram_wen), .sram_a(sram_a), .sram_q(sram_q), .l0_wr(l0_wr),
    .l0_din(l0_din), .l0_full(l0_full), .inst(inst), .ofifo_valid(ofifo_valid),
    .ofifo_dout(ofifo_dout), .ofifo_rd(ofifo_rd), .psum_cen(psum_cen),
    .psum_wen(psum_wen), .psum_a(psum_a), .psum_d(psum_d)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h want %0h", nm, cyc, act, exp);
  endtask

  // Input SRAM: registered read one cycle after CEN low.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) if (sram_cen === 1'b0) sram_q <= mem[sram_a];

  logic [PW-1:0] fifo[$];
  bit fifo_en = 0;
  bit pop_pend = 0;

  // Model state: phase 0 idle, 1 load, 2 drain, 3 fin.
  int m_phase = 0, m_rd = 0, m_wb = 0, m_len = 0, m_iss = 0, m_wr = 0, m_pop = 0;
  bit m_mode = 0, m_prev = 0;

  int start_cyc, first_wr_cyc, last_wr_cyc, done_cyc;
  int wr_cnt, iss_cnt, pop_cnt;
  bit done_seen;
  int addr_log[$];
  logic [DW-1:0] wr_log[$];
  int pa_log[$];
  logic [PW-1:0] pd_log[$];

  always @(negedge clk) begin
    bit e_iss, e_wr, e_pop;
    if (reset) begin
      m_phase = 0;
      m_prev  = 0;
      chk("rst_busy", busy, 0);      chk("rst_done", done, 0);
      chk("rst_sram_cen", sram_cen, 1); chk("rst_sram_wen", sram_wen, 1);
      chk("rst_sram_a", sram_a, 0);  chk("rst_l0_wr", l0_wr, 0);
      chk("rst_l0_din", l0_din, 0);  chk("rst_inst", inst, 0);
      chk("rst_ofifo_rd", ofifo_rd, 0); chk("rst_psum_cen", psum_cen, 1);
      chk("rst_psum_wen", psum_wen, 1); chk("rst_psum_a", psum_a, 0);
      chk("rst_psum_d", psum_d, 0);
    end else begin
      e_iss = (m_phase == 1) && (m_iss < m_len) && !l0_full && ((m_iss - m_wr - int'(m_prev)) == 0);
      e_wr  = (m_phase == 1) && !l0_full && ((m_iss - m_wr) > 0);
      e_pop = (m_phase == 2) && ofifo_valid;
      chk("busy", busy, (m_phase == 1) || (m_phase == 2));
      chk("done", done, m_phase == 3);
      chk("sram_cen", sram_cen, !e_iss);
      chk("sram_wen", sram_wen, 1);
      if (e_iss) chk("sram_a", sram_a, (m_rd + m_iss) % DEPTH);
      chk("l0_wr", l0_wr, e_wr);
      if (e_wr) begin
        chk("l0_din", l0_din, mem[(m_rd + m_wr) % DEPTH]);
        chk("inst", inst, m_mode ? 2'b10 : 2'b01);
      end else begin
        chk("inst_idle", inst, 0);
      end
      chk("ofifo_rd", ofifo_rd, e_pop);
      chk("psum_cen", psum_cen, !e_pop);
      chk("psum_wen", psum_wen, !e_pop);
      if (e_pop) begin
        chk("psum_a", psum_a, (m_wb + m_pop) % DEPTH);
        chk("psum_d", psum_d, ofifo_dout);
      end
      // Observation logs for directed literal checks.
      if (sram_cen === 1'b0) begin addr_log.push_back(int'(sram_a)); iss_cnt++; end
      if (l0_wr === 1'b1) begin
        wr_log.push_back(l0_din); wr_cnt++; last_wr_cyc = cyc;
        if (first_wr_cyc < 0) first_wr_cyc = cyc;
      end
      if (psum_cen === 1'b0) begin pa_log.push_back(int'(psum_a)); pd_log.push_back(psum_d); pop_cnt++; end
      if (done === 1'b1) begin done_seen = 1; done_cyc = cyc; end
      pop_pend = (ofifo_rd === 1'b1);
      case (m_phase)
        0: if (start) begin
          m_mode = mode; m_rd = int'(rd_base); m_wb = int'(wb_base); m_len = int'(len);
          m_iss = 0; m_wr = 0; m_pop = 0; m_prev = 0; start_cyc = cyc;
          m_phase = (m_len == 0) ? 3 : 1;
        end
        1: begin
          m_iss += int'(e_iss); m_wr += int'(e_wr); m_prev = e_iss;
          if (m_wr == m_len) m_phase = m_mode ? 2 : 3;
        end
        2: begin
          m_pop += int'(e_pop);
          if (m_pop == m_len) m_phase = 3;
        end
        default: m_phase = 0;
      endcase
    end
  end

  task automatic refresh_fifo();
    ofifo_valid = fifo_en && (fifo.size() > 0);
    ofifo_dout  = (fifo.size() > 0) ? fifo[0] : '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    if (pop_pend) begin
      if (fifo.size() > 0) void'(fifo.pop_front());
      pop_pend = 0;
    end
    refresh_fifo();
  endtask

  // full_kind: 0 never full, 1 random, 2 full on cycles 5..7 after start.
  // fifo_kind: 0 valid from 5 cycles after the last L0 write, 1 random.
  task automatic run_cmd(input bit md, input int rb, input int wb, input int ln,
                         input int full_kind, input int fifo_kind, input int extra,
                         input bit fixed_vals, input int budget);
    int sc;
    bit ok;
    fifo.delete();
    if (md) for (int i = 0; i < ln + extra; i++)
      fifo.push_back(fixed_vals ? PW'(32'hA + i) : {$urandom, $urandom, $urandom, $urandom});
    addr_log.delete(); wr_log.delete(); pa_log.delete(); pd_log.delete();
    wr_cnt = 0; iss_cnt = 0; pop_cnt = 0; done_seen = 0;
    first_wr_cyc = -1; last_wr_cyc = 0; done_cyc = 0;
    mode = md; rd_base = AW'(rb); wb_base = AW'(wb); len = (AW+1)'(ln);
    start = 1; l0_full = 0; fifo_en = 0;
    refresh_fifo();
    sc = cyc;
    ok = 0;
    for (int k = 0; k < budget; k++) begin
      tick();
      if (done_seen) begin ok = 1; break; end
      case (full_kind)
        0:       l0_full = 0;
        1:       l0_full = ($urandom_range(0, 99) < 30);
        default: l0_full = (cyc - sc >= 5) && (cyc - sc <= 7);
      endcase
      if (fifo_kind == 0) fifo_en = (wr_cnt == ln) && (cyc - last_wr_cyc >= 5);
      else                fifo_en = ($urandom_range(0, 99) < 70);
      // Stray commands while busy must be ignored.
      start = (full_kind == 1) && ($urandom_range(0, 9) == 0);
      if (start) begin len = (AW+1)'($urandom_range(0, 30)); mode = ~mode; end
      refresh_fifo();
    end
    start = 0; l0_full = 0; fifo_en = 0;
    refresh_fifo();
    chk("cmd_timeout", ok, 1);
    if (md && ln > 0) chk("fifo_leftover", fifo.size(), extra);
  endtask

  initial begin
    int exp_w[4];
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    #1 reset = 1;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    tick();

    // Mode 0, 8 words, no back-pressure.
    run_cmd(0, 0, 0, 8, 0, 0, 0, 0, 100);
    chk("t1_first_wr", first_wr_cyc - start_cyc, 2);
    chk("t1_done_lat", done_cyc - start_cyc, 10);
    chk("t1_wr_cnt", wr_cnt, 8);
    chk("t1_psum_cnt", pop_cnt, 0);
    chk("t1_addr_cnt", addr_log.size(), 8);
    for (int i = 0; i < 8; i++) chk("t1_addr", addr_log[i], i);

    // Mode 1, 4 words, FIFO entries A..D arriving late.
    run_cmd(1, 16, 100, 4, 0, 0, 0, 1, 100);
    chk("t2_pop_cnt", pop_cnt, 4);
    for (int i = 0; i < 4; i++) begin
      chk("t2_psum_a", pa_log[i], 100 + i);
      chk("t2_psum_d", pd_log[i], 32'hA + i);
    end
    chk("t2_done_lat", done_cyc - start_cyc, 14);

    // Back-pressure on word 3's return for 3 cycles.
    run_cmd(0, 40, 0, 8, 2, 0, 0, 0, 100);
    chk("t3_wr_cnt", wr_cnt, 8);
    for (int i = 0; i < 8; i++) chk("t3_word", wr_log[i], mem[40 + i]);
    chk("t3_done_lat", done_cyc - start_cyc, 14);

    // Address wrap past the top of the SRAM.
    run_cmd(0, 2046, 0, 4, 0, 0, 0, 0, 100);
    exp_w = '{2046, 2047, 0, 1};
    for (int i = 0; i < 4; i++) chk("t4_wrap_addr", addr_log[i], exp_w[i]);

    // Zero-length commands.
    run_cmd(0, 5, 0, 0, 0, 0, 0, 0, 20);
    chk("t5_done_lat", done_cyc - start_cyc, 1);
    chk("t5_no_reads", iss_cnt, 0);
    run_cmd(1, 5, 9, 0, 0, 1, 0, 0, 20);
    chk("t5_no_psum", pop_cnt, 0);

    // Reset in the middle of LOAD.
    mode = 0; rd_base = AW'(200); len = (AW+1)'(8); start = 1;
    done_seen = 0;
    tick(); start = 0;
    repeat (4) tick();
    reset = 1; #1;
    chk("t6_cen_now", sram_cen, 1);
    chk("t6_wr_now", l0_wr, 0);
    chk("t6_busy_now", busy, 0);
    tick(); tick();
    reset = 0;
    tick();
    chk("t6_no_done", done_seen, 0);
    run_cmd(0, 300, 0, 2, 0, 0, 0, 0, 50);
    chk("t6_done_lat", done_cyc - start_cyc, 4);
    chk("t6_wr_cnt", wr_cnt, 2);

    // Whole-SRAM pass with wrap.
    run_cmd(0, 7, 0, DEPTH, 0, 0, 0, 0, DEPTH + 100);
    chk("t7_wr_cnt", wr_cnt, DEPTH);
    chk("t7_done_lat", done_cyc - start_cyc, DEPTH + 2);
    chk("t7_addr_last", addr_log[DEPTH-1], 6);

    // Randomised commands with back-pressure and bursty FIFO.
    for (int n = 0; n < 40; n++) begin
      int ln;
      ln = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 24));
      run_cmd(1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH-1)),
              int'($urandom_range(0, DEPTH-1)), ln, 1, 1,
              int'($urandom_range(0, 2)), 0, 2000);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule

// File: doc/core_ctrl.md
Name: core_ctrl

Overview:
- Parametrised sequencer for the core.
- Reads activation/weight words from the input SRAM, streams them into the corelet L0 buffer under back-pressure, and tags each word with the array instruction.
- In execute mode, also drains the corelet output FIFO into the psum SRAM.
- Replaces hand-driven SRAM/corelet strobes with a start/done command interface, and generalises row, col, bit widths and SRAM depth.

Parameters:
- bw, 4, activation/weight bit width
- psum_bw, 16, partial-sum bit width
- row, 8, array rows (input word = row*bw bits)
- col, 8, array columns (psum word = col*psum_bw bits)
- addr_w, 11, SRAM address width (depth 2**addr_w; 11 gives 2048)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle command strobe, sampled only in IDLE
- mode  in  1  0 = kernel load, 1 = execute
- rd_base  in  addr_w  first input-SRAM address
- wb_base  in  addr_w  first psum-SRAM address
- len  in  addr_w+1  number of words (0..2**addr_w)
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse at command completion
- sram_cen  out  1  input SRAM chip enable, active-low
- sram_wen  out  1  input SRAM write enable, active-low; tied 1 (read only)
- sram_a  out  addr_w  input SRAM address
- sram_q  in  row*bw  input SRAM read data, valid one cycle after CEN=0
- l0_wr  out  1  L0 write strobe
- l0_din  out  row*bw  L0 write data
- l0_full  in  1  L0 cannot accept a write this cycle
- inst  out  2  [0] kernel load, [1] execute; qualified by l0_wr
- ofifo_valid  in  1  output FIFO non-empty
- ofifo_dout  in  col*psum_bw  output FIFO head
- ofifo_rd  out  1  pop output FIFO
- psum_cen  out  1  psum SRAM chip enable, active-low
- psum_wen  out  1  psum SRAM write enable, active-low
- psum_a  out  addr_w  psum SRAM address
- psum_d  out  col*psum_bw  psum SRAM write data

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, l0_wr=0, inst=0, ofifo_rd=0; sram_cen=1, sram_wen=1, psum_cen=1, psum_wen=1; addresses/data=0; counters and hold register cleared. A command in flight is abandoned without a done pulse.
- States: IDLE, LOAD, DRAIN, WB, FIN.
- IDLE:
  - start=1 latches mode, bases and len.
  - len=0 -> FIN (no SRAM or L0 activity).
  - Otherwise -> LOAD.
  - start in any other state is ignored.
- LOAD, read issue: a read is issued in cycle t (sram_cen=0, sram_a=rd_base+issued) only if issued<len, l0_full=0 and the hold register is empty.
- LOAD, read return: data returns at t+1.
  - If l0_full=0 at t+1: l0_wr=1, l0_din=sram_q.
  - Otherwise: data goes to a 1-entry hold register and is written on the first cycle l0_full=0.
  - A hold write takes priority over new return data; no word is dropped or duplicated.
- inst with every l0_wr: mode 0 -> 2'b01; mode 1 -> 2'b10.
- LOAD exit, when written==len:
  - mode 0 -> FIN.
  - mode 1 -> DRAIN.
- DRAIN/WB: one state pair, no extra wait.
  - Each cycle with ofifo_valid=1: ofifo_rd=1, psum_cen=0, psum_wen=0, psum_a=wb_base+popped, psum_d=ofifo_dout (same cycle).
  - After len pops -> FIN. Extra FIFO entries are not popped.
- FIN: done=1 for one cycle, busy drops in the same cycle -> IDLE.
- Address arithmetic: modulo 2**addr_w; wrap past top is legal. len=2**addr_w covers the whole SRAM exactly once.
- Throughput: one word/cycle sustained when l0_full stays 0. First l0_wr occurs 2 cycles after start.

Decomposition:
- Shared package core_pkg holds:
  - state encoding enum
  - inst encodings INST_KLOAD=2'b01, INST_EXEC=2'b10
  - mode constants
- One natural sub-module: core_rd_stream (read issue counter, 1-cycle return tracking, hold register, L0 write). core_ctrl owns the FSM and writeback.

Test Plan:
- Mode 0, rd_base=0, len=8, l0_full=0: sram_a 0..7 on consecutive cycles; 8 l0_wr each with inst=01; done 10 cycles after start; no psum writes.
- Mode 1, len=4, ofifo_valid raised 5 cycles after the last l0_wr with values A..D: psum writes at wb_base..wb_base+3 with data A..D; then done.
- l0_full asserted on the return cycle of word 3 for 3 cycles: word 3 held, then written; L0 receives words 0..7 exactly once in order.
- rd_base=2046, len=4, addr_w=11: sram_a 2046, 2047, 0, 1.
- len=0: done the cycle after start; sram_cen and psum_cen stay 1.
- Reset asserted mid-LOAD: all strobes inactive immediately; no done; next start with len=2 completes normally.
